// File: rtl/data_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_if
//  Purpose  : Request/response bus between the memory stage (master) and the
//             quadword data memory (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface data_mem_if;
  logic        req_valid;
  logic        req_write;
  logic [63:0] mem_add;
  logic [63:0] mem_data;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] val_m;
  logic        bad_mem;

  modport master (
    output req_valid, req_write, mem_add, mem_data, resp_ready,
    input  req_ready, resp_valid, val_m, bad_mem
  );

  modport slave (
    input  req_valid, req_write, mem_add, mem_data, resp_ready,
    output req_ready, resp_valid, val_m, bad_mem
  );
endinterface
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem
//  Purpose  : DEPTH x 64-bit data memory with a valid/ready request and
//             response handshake. Misaligned or out-of-range byte addresses
//             return bad_mem=1 without touching the array.
//  Options  : DMEM_WAIT_EN - insert WAIT_CYCLES wait states between accept
//             and response (IDLE->WAIT->RESP instead of IDLE->RESP).
//  Revision : 1.0  initial release
// ============================================================================
module data_mem #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam int          C_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Byte-address limit kept at full 64-bit width so high address bits are
  // never silently dropped by the range check.
  localparam logic [63:0] C_LIMIT = 64'(DEPTH) << 3;

  if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_wait_range_chk
    $error("data_mem: WAIT_CYCLES must be within 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [63:0] r_val_m;
  logic        r_bad_mem;
  logic [63:0] r_mem [DEPTH];

  logic               w_accept;
  logic               w_enter_resp;
  logic               w_acc_write;
  logic [63:0]        w_acc_add;
  logic [63:0]        w_acc_data;
  logic               w_err;
  logic [C_IDX_W-1:0] w_idx;
  logic               w_commit;

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;

`ifdef DMEM_WAIT_EN
  // Request captured at accept; the access is performed from these copies
  // so later activity on the request inputs cannot disturb it.
  logic        r_write;
  logic [63:0] r_add;
  logic [63:0] r_data;
  logic [3:0]  r_wait_cnt;

  assign w_acc_write  = r_write;
  assign w_acc_add    = r_add;
  assign w_acc_data   = r_data;
  assign w_enter_resp = (r_state == S_WAIT) && (r_wait_cnt == 4'd0);
`else
  // Without wait states the access completes on the accept edge itself, so
  // the live request inputs are the captured values.
  assign w_acc_write  = bus.req_write;
  assign w_acc_add    = bus.mem_add;
  assign w_acc_data   = bus.mem_data;
  assign w_enter_resp = w_accept;
`endif

  assign w_err    = (w_acc_add[2:0] != 3'd0) || (w_acc_add >= C_LIMIT);
  assign w_idx    = w_acc_add[C_IDX_W+2:3];
  // Reset gating keeps a request seen while reset is high from committing.
  assign w_commit = w_enter_resp && w_acc_write && !w_err && !reset;

  // Array write port; storage has no reset so contents survive it.
  always_ff @(posedge clock) begin
    if (w_commit) begin
      r_mem[w_idx] <= w_acc_data;
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_val_m      <= 64'd0;
      r_bad_mem    <= 1'b0;
`ifdef DMEM_WAIT_EN
      r_write      <= 1'b0;
      r_add        <= 64'd0;
      r_data       <= 64'd0;
      r_wait_cnt   <= 4'd0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
`ifdef DMEM_WAIT_EN
            r_write     <= bus.req_write;
            r_add       <= bus.mem_add;
            r_data      <= bus.mem_data;
            r_wait_cnt  <= 4'(WAIT_CYCLES - 1);
            r_state     <= S_WAIT;
`endif
          end
        end
`ifdef DMEM_WAIT_EN
        S_WAIT: begin
          if (r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
`endif
        S_RESP: begin
          // Outputs hold until the master takes the response; req_ready
          // only returns on the edge that completes the handshake.
          if (bus.resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase

      // Response contents are registered once, on entry to RESP.
      if (w_enter_resp) begin
        r_state      <= S_RESP;
        r_resp_valid <= 1'b1;
        r_bad_mem    <= w_err;
        r_val_m      <= (w_err || w_acc_write) ? 64'd0 : r_mem[w_idx];
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.val_m      = r_val_m;
  assign bus.bad_mem    = r_bad_mem;

endmodule
`default_nettype wire
